// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the 5-stage RV32 pipeline: EX operand forwarding,
// load-use stalls, branch flushes and multi-cycle EX sequencing.
module pipeline_hazard_ctrl #(
  parameter int CNT_W         = 16,
  parameter int MC_MAX_CYCLES = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             LoadE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             PCSrcE,
  input  logic             MultiCycleE,
  input  logic             MultiCycleDone,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushM,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount,
  output logic             McTimeout
);

  localparam int BC_W = $clog2(MC_MAX_CYCLES + 1);

  typedef enum logic {RUN, MC_BUSY} state_t;

  state_t          state, state_nxt;
  logic [BC_W-1:0] busy_cnt, busy_cnt_nxt;
  logic            timeout_set;
  logic            lw_stall;

  // MEM result is newer than WB, so it takes priority; x0 is never forwarded.
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (!reset) begin
      if (RegWriteM && RdM != 5'd0 && RdM == Rs1E)      ForwardAE = 2'b10;
      else if (RegWriteW && RdW != 5'd0 && RdW == Rs1E) ForwardAE = 2'b01;
      if (RegWriteM && RdM != 5'd0 && RdM == Rs2E)      ForwardBE = 2'b10;
      else if (RegWriteW && RdW != 5'd0 && RdW == Rs2E) ForwardBE = 2'b01;
    end
  end

  assign lw_stall = LoadE && (RdE != 5'd0) && (RdE == Rs1D || RdE == Rs2D);

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned; a missing default here would infer a latch.
  always_comb begin
    state_nxt    = state;
    busy_cnt_nxt = busy_cnt;
    timeout_set  = 1'b0;
    StallF       = 1'b0;
    StallD       = 1'b0;
    StallE       = 1'b0;
    FlushD       = 1'b0;
    FlushE       = 1'b0;
    FlushM       = 1'b0;
    case (state)
      RUN: begin
        if (MultiCycleE && !MultiCycleDone) begin
          {StallF, StallD, StallE, FlushM} = 4'b1111;
          state_nxt    = MC_BUSY;
          busy_cnt_nxt = BC_W'(1);
        end else if (PCSrcE) begin
          // A taken branch squashes the ID instruction, so its load-use stall is moot.
          {FlushD, FlushE} = 2'b11;
        end else if (lw_stall) begin
          {StallF, StallD, FlushE} = 3'b111;
        end
      end
      MC_BUSY: begin
        if (MultiCycleDone) begin
          state_nxt = RUN;
        end else if (busy_cnt == BC_W'(MC_MAX_CYCLES)) begin
          timeout_set = 1'b1;
          state_nxt   = RUN;
        end else begin
          {StallF, StallD, StallE, FlushM} = 4'b1111;
          busy_cnt_nxt = busy_cnt + BC_W'(1);
        end
      end
      default: state_nxt = RUN;
    endcase
    // Outputs are Mealy, so reset must mask them combinationally, not just at the next edge.
    if (reset) begin
      {StallF, StallD, StallE, FlushD, FlushE, FlushM} = 6'b0;
      timeout_set = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= RUN;
      busy_cnt   <= '0;
      StallCount <= '0;
      FlushCount <= '0;
      McTimeout  <= 1'b0;
    end else begin
      state    <= state_nxt;
      busy_cnt <= busy_cnt_nxt;
      if (timeout_set)                   McTimeout  <= 1'b1;
      if (StallF && StallCount != '1)    StallCount <= StallCount + CNT_W'(1);
      if (FlushD && FlushCount != '1)    FlushCount <= FlushCount + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: table-driven single-cycle
// vectors plus hand-written multi-cycle, timeout and async-reset sequences.
module tb_pipeline_hazard_ctrl;

  localparam int CNT_W = 16;
  localparam int MCMAX = 8;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic LoadE, RegWriteM, RegWriteW, PCSrcE, MultiCycleE, MultiCycleDone;
  logic [1:0] ForwardAE, ForwardBE;
  logic StallF, StallD, StallE, FlushD, FlushE, FlushM;
  logic [CNT_W-1:0] StallCount, FlushCount;
  logic McTimeout;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.CNT_W(CNT_W), .MC_MAX_CYCLES(MCMAX)) dut (
    .clk(clk), .reset(reset),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .LoadE(LoadE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .PCSrcE(PCSrcE), .MultiCycleE(MultiCycleE), .MultiCycleDone(MultiCycleDone),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
    .StallCount(StallCount), .FlushCount(FlushCount), .McTimeout(McTimeout)
  );

  always @(posedge clk)
    if (!reset) assert (!(MultiCycleE && PCSrcE)) else $error("MultiCycleE and PCSrcE both high");

  // ctl bit order: {StallF, StallD, StallE, FlushD, FlushE, FlushM}
  typedef struct packed {
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic       ld, rwm, rww, pc, mc, dn;
    logic [1:0] fa, fb;
    logic [5:0] ctl;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs[NV];
  int   passed = 0;
  int   total  = 0;
  int   exp_stall = 0;
  int   exp_flush = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else passed++;
  endtask

  function automatic vec_t mk(int rs1d, int rs2d, int rs1e, int rs2e, int rde, int rdm, int rdw,
                              int ld, int rwm, int rww, int pc, int mc, int dn,
                              int fa, int fb, int ctl);
    vec_t v;
    v.rs1d = 5'(rs1d); v.rs2d = 5'(rs2d); v.rs1e = 5'(rs1e); v.rs2e = 5'(rs2e);
    v.rde = 5'(rde); v.rdm = 5'(rdm); v.rdw = 5'(rdw);
    v.ld = 1'(ld); v.rwm = 1'(rwm); v.rww = 1'(rww); v.pc = 1'(pc);
    v.mc = 1'(mc); v.dn = 1'(dn);
    v.fa = 2'(fa); v.fb = 2'(fb); v.ctl = 6'(ctl);
    return v;
  endfunction

  task automatic drive_idle();
    {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
    {LoadE, RegWriteM, RegWriteW, PCSrcE, MultiCycleE, MultiCycleDone} = '0;
  endtask

  task automatic drive_lw();
    LoadE = 1'b1; RdE = 5'd7; Rs1D = 5'd7;
  endtask

  function automatic logic [5:0] ctl_now();
    return {StallF, StallD, StallE, FlushD, FlushE, FlushM};
  endfunction

  initial begin
    //                rs1d rs2d rs1e rs2e rde rdm rdw ld rwm rww pc mc dn  fa     fb     ctl
    vecs[0]  = mk(0,   0,   5,   0,   0,  5,  5,  0, 1,  1,  0, 0, 0, 2'b10, 2'b00, 6'b000000);
    vecs[1]  = mk(0,   0,   0,   0,   0,  0,  0,  0, 1,  1,  0, 0, 0, 2'b00, 2'b00, 6'b000000);
    vecs[2]  = mk(0,   0,   5,   0,   0,  5,  5,  0, 0,  1,  0, 0, 0, 2'b01, 2'b00, 6'b000000);
    vecs[3]  = mk(0,   0,   3,   4,   0,  4,  3,  0, 1,  1,  0, 0, 0, 2'b01, 2'b10, 6'b000000);
    vecs[4]  = mk(0,   7,   0,   0,   7,  0,  0,  1, 0,  0,  0, 0, 0, 2'b00, 2'b00, 6'b110010);
    vecs[5]  = mk(0,   0,   0,   0,   0,  0,  0,  1, 0,  0,  0, 0, 0, 2'b00, 2'b00, 6'b000000);
    vecs[6]  = mk(9,   0,   0,   0,   9,  0,  0,  1, 0,  0,  0, 0, 0, 2'b00, 2'b00, 6'b110010);
    vecs[7]  = mk(7,   0,   0,   0,   7,  0,  0,  0, 0,  0,  0, 0, 0, 2'b00, 2'b00, 6'b000000);
    vecs[8]  = mk(7,   0,   0,   0,   7,  0,  0,  1, 0,  0,  1, 0, 0, 2'b00, 2'b00, 6'b000110);
    vecs[9]  = mk(0,   0,   0,   0,   0,  0,  0,  0, 0,  0,  1, 0, 0, 2'b00, 2'b00, 6'b000110);
    vecs[10] = mk(0,   0,   0,   0,   0,  0,  0,  0, 0,  0,  0, 1, 1, 2'b00, 2'b00, 6'b000000);
    vecs[11] = mk(0,   0,   0,   8,   0,  0,  8,  0, 1,  1,  0, 0, 0, 2'b00, 2'b01, 6'b000000);

    // Reset state: hazard-causing inputs must be masked while reset is high.
    reset = 1'b1;
    drive_idle();
    drive_lw();
    RegWriteM = 1'b1; RdM = 5'd5; Rs1E = 5'd5;
    #3;
    check("rst_ctl", ctl_now(), 6'b0);
    check("rst_fwd_a", ForwardAE, 2'b00);
    check("rst_stall_cnt", StallCount, 0);
    check("rst_flush_cnt", FlushCount, 0);
    check("rst_timeout", McTimeout, 0);
    @(negedge clk);
    reset = 1'b0;
    drive_idle();

    // Single-cycle vectors in RUN; counters tracked by the bench.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} =
        {vecs[i].rs1d, vecs[i].rs2d, vecs[i].rs1e, vecs[i].rs2e, vecs[i].rde, vecs[i].rdm, vecs[i].rdw};
      {LoadE, RegWriteM, RegWriteW, PCSrcE, MultiCycleE, MultiCycleDone} =
        {vecs[i].ld, vecs[i].rwm, vecs[i].rww, vecs[i].pc, vecs[i].mc, vecs[i].dn};
      #1;
      check($sformatf("v%0d_fwd_a", i), ForwardAE, vecs[i].fa);
      check($sformatf("v%0d_fwd_b", i), ForwardBE, vecs[i].fb);
      check($sformatf("v%0d_ctl", i), ctl_now(), vecs[i].ctl);
      exp_stall += int'(vecs[i].ctl[5]);
      exp_flush += int'(vecs[i].ctl[2]);
      @(posedge clk); #1;
      check($sformatf("v%0d_stall_cnt", i), StallCount, exp_stall);
      check($sformatf("v%0d_flush_cnt", i), FlushCount, exp_flush);
    end

    // Multi-cycle op: Done arrives in cycle 3; lwStall in cycle 1 must be ignored.
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      drive_idle();
      MultiCycleE = 1'b1;
      MultiCycleDone = (c == 3);
      if (c == 1) drive_lw();
      #1;
      check($sformatf("mc_c%0d_ctl", c), ctl_now(), (c < 3) ? 6'b111001 : 6'b000000);
      if (c < 3) exp_stall++;
    end
    @(negedge clk);
    drive_idle();
    drive_lw();
    #1;
    check("mc_back_in_run", ctl_now(), 6'b110010);
    exp_stall++;
    @(posedge clk); #1;
    check("mc_stall_cnt", StallCount, exp_stall);
    check("mc_flush_cnt", FlushCount, exp_flush);

    // Timeout: Done never arrives; stalls last MCMAX cycles, then drop.
    for (int c = 0; c <= MCMAX; c++) begin
      @(negedge clk);
      drive_idle();
      MultiCycleE = 1'b1;
      #1;
      if (c < MCMAX) begin
        if (ctl_now() !== 6'b111001 || McTimeout !== 1'b0)
          check($sformatf("to_c%0d_ctl", c), {McTimeout, ctl_now()}, 7'b0111001);
        exp_stall++;
      end else begin
        check("to_release_ctl", ctl_now(), 6'b0);
        check("to_not_yet_set", McTimeout, 0);
      end
    end
    @(negedge clk);
    drive_idle();
    #1;
    check("to_flag_set", McTimeout, 1);
    check("to_idle_ctl", ctl_now(), 6'b0);
    check("to_stall_cnt", StallCount, exp_stall);
    // A later, well-behaved multi-cycle op must not clear the sticky flag.
    @(negedge clk);
    MultiCycleE = 1'b1;
    @(negedge clk);
    MultiCycleDone = 1'b1;
    #1;
    check("to_done_ctl", ctl_now(), 6'b0);
    exp_stall++;
    @(negedge clk);
    drive_idle();
    #1;
    check("to_flag_sticky", McTimeout, 1);
    check("to_stall_cnt2", StallCount, exp_stall);

    // Async reset between edges while in MC_BUSY.
    @(negedge clk);
    MultiCycleE = 1'b1;
    @(negedge clk);
    RegWriteW = 1'b1; RdW = 5'd4; Rs2E = 5'd4;
    #1;
    check("ar_busy_ctl", ctl_now(), 6'b111001);
    #2;
    reset = 1'b1;
    #1;
    check("ar_ctl", ctl_now(), 6'b0);
    check("ar_fwd_b", ForwardBE, 2'b00);
    check("ar_stall_cnt", StallCount, 0);
    check("ar_flush_cnt", FlushCount, 0);
    check("ar_timeout", McTimeout, 0);
    @(negedge clk);
    reset = 1'b0;
    drive_idle();
    #1;
    check("ar_run_idle", ctl_now(), 6'b0);
    @(negedge clk);
    drive_lw();
    #1;
    check("ar_run_lw", ctl_now(), 6'b110010);
    @(posedge clk); #1;
    check("ar_stall_cnt_after", StallCount, 1);
    check("ar_timeout_after", McTimeout, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
